// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, sync-window helpers and the coordinate type
// used by the timing generator and the sprite/ROM drawers.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  // The sync pulse starts right after the front porch and spans the sync width.
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(input int active, input int fp, input int sync_w);
    return active + fp + sync_w;
  endfunction

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = sync_start(H_ACTIVE, H_FP);
  localparam int HS_END   = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam int VS_START = sync_start(V_ACTIVE, V_FP);
  localparam int VS_END   = sync_end(V_ACTIVE, V_FP, V_SYNC);

endpackage

// File: rtl/sync_delay_line.sv
// Reset-loadable shift register that lines up sync/blank with the drawers' pipeline.
// DEPTH=0 is a plain wire.
module sync_delay_line #(
  parameter int                 WIDTH     = 3,
  parameter int                 DEPTH     = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused_ok;
    assign w_unused_ok = ^{i_clk, i_reset};
    assign o_q         = i_d;
  end else begin : g_shift
    logic [WIDTH-1:0] r_stage [DEPTH];

    // NOTE: every stage is reset, not just the output, so a sync pulse captured
    // before reset can never walk out of the pipe afterwards.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
      end else begin
        r_stage[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: pixel/line counters, blank and delayed sync,
// plus frame counter and slow animation tick for the sprite drawers.
module vga_timing_gen #(
  parameter int H_ACTIVE        = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP            = vga_timing_pkg::H_FP,
  parameter int H_SYNC          = vga_timing_pkg::H_SYNC,
  parameter int H_BP            = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE        = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP            = vga_timing_pkg::V_FP,
  parameter int V_SYNC          = vga_timing_pkg::V_SYNC,
  parameter int V_BP            = vga_timing_pkg::V_BP,
  parameter int PIPE_DELAY      = 2,
  parameter int FRAMES_PER_TICK = 8
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  output vga_timing_pkg::coord_t DrawX,
  output vga_timing_pkg::coord_t DrawY,
  output logic                   blank,
  output logic                   blank_d,
  output logic                   hs,
  output logic                   vs,
  output logic                   sync,
  output logic                   frame_start,
  output logic [7:0]             frame_count,
  output logic                   anim_tick
);

  import vga_timing_pkg::*;

  localparam int LP_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int LP_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LP_HS_START = sync_start(H_ACTIVE, H_FP);
  localparam int LP_HS_END   = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam int LP_VS_START = sync_start(V_ACTIVE, V_FP);
  localparam int LP_VS_END   = sync_end(V_ACTIVE, V_FP, V_SYNC);

  coord_t     r_hc;
  coord_t     r_vc;
  logic [7:0] r_fc;
  logic [7:0] r_tc;
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic       w_frame_start;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (r_hc == coord_t'(LP_H_TOTAL - 1)) begin
      r_hc <= '0;
      r_vc <= (r_vc == coord_t'(LP_V_TOTAL - 1)) ? '0 : r_vc + 1'b1;
    end else begin
      r_hc <= r_hc + 1'b1;
    end
  end

  assign w_frame_start = (r_hc == '0) && (r_vc == '0);

  // Frame and tick counters step on the first pixel of each frame.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_fc <= '0;
      r_tc <= '0;
    end else if (w_frame_start) begin
      r_fc <= r_fc + 1'b1;
      r_tc <= (r_tc == 8'(FRAMES_PER_TICK - 1)) ? '0 : r_tc + 1'b1;
    end
  end

  assign w_hs_raw = !((r_hc >= coord_t'(LP_HS_START)) && (r_hc < coord_t'(LP_HS_END)));
  assign w_vs_raw = !((r_vc >= coord_t'(LP_VS_START)) && (r_vc < coord_t'(LP_VS_END)));
  assign blank    = (r_hc < coord_t'(H_ACTIVE)) && (r_vc < coord_t'(V_ACTIVE));

  sync_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (3'b110)
  ) u_sync_delay (
    .i_clk   (vga_clk),
    .i_reset (reset),
    .i_d     ({w_hs_raw, w_vs_raw, blank}),
    .o_q     ({hs, vs, blank_d})
  );

  assign DrawX       = r_hc;
  assign DrawY       = r_vc;
  assign sync        = 1'b0;
  assign frame_start = w_frame_start;
  assign frame_count = r_fc;
  assign anim_tick   = w_frame_start && (r_tc == 8'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full 640x480 timing for line-level checks, scaled
// timings for frame, tick, wrap, mid-sync reset and pipe-delay sweep.
module tb_vga_timing_gen;

  // DUT0: real timing, delay 2. DUT1: 96x32 raster, delay 4. DUT2: 12x7 raster, delay 0.
  localparam int HA  [3] = '{640, 64, 8};
  localparam int HF  [3] = '{16, 8, 1};
  localparam int HS  [3] = '{96, 16, 2};
  localparam int HB  [3] = '{48, 8, 1};
  localparam int VA  [3] = '{480, 24, 4};
  localparam int VF  [3] = '{10, 3, 1};
  localparam int VS  [3] = '{2, 2, 1};
  localparam int VB  [3] = '{33, 3, 1};
  localparam int PD  [3] = '{2, 4, 0};
  localparam int FPT [3] = '{8, 8, 1};

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic [2:0]      rst = 3'b111;
  logic [2:0][9:0] ox, oy;
  logic [2:0][7:0] ofc;
  logic [2:0]      obl, obd, ohs, ovs, osy, ofs, otk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vga_timing_gen #(
      .H_ACTIVE (HA[g]), .H_FP (HF[g]), .H_SYNC (HS[g]), .H_BP (HB[g]),
      .V_ACTIVE (VA[g]), .V_FP (VF[g]), .V_SYNC (VS[g]), .V_BP (VB[g]),
      .PIPE_DELAY (PD[g]), .FRAMES_PER_TICK (FPT[g])
    ) u_dut (
      .vga_clk     (clk),
      .reset       (rst[g]),
      .DrawX       (ox[g]),
      .DrawY       (oy[g]),
      .blank       (obl[g]),
      .blank_d     (obd[g]),
      .hs          (ohs[g]),
      .vs          (ovs[g]),
      .sync        (osy[g]),
      .frame_start (ofs[g]),
      .frame_count (ofc[g]),
      .anim_tick   (otk[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state per DUT
  int          mx[3], my[3], mfc[3], mtc[3], mn[3], merr[3], mfirst[3];
  logic [2:0]  hist[3][8];
  logic [34:0] mexp[3], mobs[3];

  function automatic logic [2:0] raw_sync(input int d, input int x, input int y);
    logic h, v, b;
    h = !(x >= HA[d] + HF[d] && x < HA[d] + HF[d] + HS[d]);
    v = !(y >= VA[d] + VF[d] && y < VA[d] + VF[d] + VS[d]);
    b = (x < HA[d]) && (y < VA[d]);
    return {h, v, b};
  endfunction

  task automatic model_reset(input int d);
    mx[d] = 0; my[d] = 0; mfc[d] = 0; mtc[d] = 0; mn[d] = 0;
    for (int k = 0; k < 8; k++) hist[d][k] = 3'b110;
  endtask

  // Compare every output against the model for the current sample, then advance.
  task automatic model_check(input int d);
    logic [2:0]  r, dl;
    logic        fs;
    logic [34:0] e, o;
    r = raw_sync(d, mx[d], my[d]);
    if (PD[d] == 0) dl = r;
    else            dl = hist[d][PD[d]-1];
    for (int k = 7; k > 0; k--) hist[d][k] = hist[d][k-1];
    hist[d][0] = r;
    fs = (mx[d] == 0) && (my[d] == 0);
    e = {10'(mx[d]), 10'(my[d]), r[0], fs, 8'(mfc[d]), fs && (mtc[d] == 0), dl, 1'b0};
    o = {ox[d], oy[d], obl[d], ofs[d], ofc[d], otk[d], ohs[d], ovs[d], obd[d], osy[d]};
    if (o !== e) begin
      if (merr[d] == 0) begin
        mfirst[d] = mn[d]; mexp[d] = e; mobs[d] = o;
      end
      merr[d]++;
    end
    if (fs) begin
      mfc[d] = (mfc[d] + 1) % 256;
      mtc[d] = (mtc[d] == FPT[d] - 1) ? 0 : mtc[d] + 1;
    end
    mn[d]++;
    if (mx[d] == HA[d] + HF[d] + HS[d] + HB[d] - 1) begin
      mx[d] = 0;
      my[d] = (my[d] == VA[d] + VF[d] + VS[d] + VB[d] - 1) ? 0 : my[d] + 1;
    end else begin
      mx[d]++;
    end
  endtask

  task automatic report_model(input int d, input string name);
    n_cmp++;
    if (merr[d] !== 0) begin
      n_bad++;
      $display("FAIL %s: %0d samples differ, first at sample %0d got %h want %h",
               name, merr[d], mfirst[d], mobs[d], mexp[d]);
    end
    merr[d] = 0;
  endtask

  task automatic step(input int d);
    @(negedge clk);
    model_check(d);
  endtask

  // Hold reset for 'cycles' edges, release, and check sample 0 against the model.
  task automatic reset_dut(input int d, input int cycles);
    @(negedge clk);
    rst[d] = 1'b1;
    repeat (cycles) @(negedge clk);
    rst[d] = 1'b0;
    model_reset(d);
    model_check(d);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst[0] = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({ox[0], oy[0], ohs[0], ovs[0], obd[0], ofc[0]} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_held: x=%0d y=%0d hs=%b vs=%b bd=%b fc=%0d want 0 0 1 1 0 0",
               ox[0], oy[0], ohs[0], ovs[0], obd[0], ofc[0]);
    end
    rst[0] = 1'b0;
    model_reset(0);
    n_cmp++;
    if ({ox[0], oy[0]} !== 20'd0) begin
      n_bad++; $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", ox[0], oy[0]);
    end
    n_cmp++;
    if ({ofs[0], otk[0]} !== 2'b11) begin
      n_bad++; $display("FAIL reset_pulses: got fs=%b tick=%b want 1 1", ofs[0], otk[0]);
    end
    n_cmp++;
    if ({ohs[0], ovs[0], ofc[0]} !== {1'b1, 1'b1, 8'd0}) begin
      n_bad++; $display("FAIL reset_sync_fc: got hs=%b vs=%b fc=%0d want 1 1 0", ohs[0], ovs[0], ofc[0]);
    end
    model_check(0);
  endtask

  task automatic test_line();
    logic e;
    for (int n = 1; n <= 810; n++) begin
      step(0);
      if (n == 657 || n == 658 || n == 753 || n == 754) begin
        e = !(n == 658 || n == 753);
        n_cmp++;
        if (ohs[0] !== e) begin
          n_bad++; $display("FAIL line_hs_edge@%0d: got %b want %b", n, ohs[0], e);
        end
      end
      if (n == 639 || n == 640) begin
        e = (n == 639);
        n_cmp++;
        if (obl[0] !== e) begin
          n_bad++; $display("FAIL line_blank@%0d: got %b want %b", n, obl[0], e);
        end
      end
      if (n == 641 || n == 642) begin
        e = (n == 641);
        n_cmp++;
        if (obd[0] !== e) begin
          n_bad++; $display("FAIL line_blank_d@%0d: got %b want %b", n, obd[0], e);
        end
      end
      if (n == 799) begin
        n_cmp++;
        if ({ox[0], oy[0]} !== {10'd799, 10'd0}) begin
          n_bad++; $display("FAIL line_end: got x=%0d y=%0d want 799 0", ox[0], oy[0]);
        end
      end
      if (n == 800) begin
        n_cmp++;
        if ({ox[0], oy[0], ofs[0]} !== {10'd0, 10'd1, 1'b0}) begin
          n_bad++; $display("FAIL line_wrap: got x=%0d y=%0d fs=%b want 0 1 0", ox[0], oy[0], ofs[0]);
        end
      end
    end
    report_model(0, "model_full_timing");
  endtask

  task automatic test_frame();
    int period = -1, vslow = 0, blank_late = 0, first_vs = -1;
    reset_dut(1, 3);
    for (int n = 1; n <= 3200; n++) begin
      step(1);
      if (!ovs[1]) begin
        vslow++;
        if (first_vs < 0) first_vs = n;
      end
      if (obl[1] && oy[1] >= 10'd24) blank_late++;
      if (ofs[1]) begin
        period = n;
        break;
      end
    end
    n_cmp++;
    if (period !== 3072) begin
      n_bad++; $display("FAIL frame_period: got %0d want 3072", period);
    end
    n_cmp++;
    if (vslow !== 192) begin
      n_bad++; $display("FAIL frame_vs_width: got %0d want 192", vslow);
    end
    n_cmp++;
    if (first_vs !== 2596) begin
      n_bad++; $display("FAIL frame_vs_start: got %0d want 2596", first_vs);
    end
    n_cmp++;
    if (blank_late !== 0) begin
      n_bad++; $display("FAIL frame_blank_vbi: got %0d want 0", blank_late);
    end
    n_cmp++;
    if (ofc[1] !== 8'd1) begin
      n_bad++; $display("FAIL frame_count_at_fs: got %0d want 1", ofc[1]);
    end
    step(1);
    n_cmp++;
    if (ofc[1] !== 8'd2) begin
      n_bad++; $display("FAIL frame_count_after_fs: got %0d want 2", ofc[1]);
    end
    report_model(1, "model_frame");
  endtask

  task automatic test_anim();
    int ticks = 0, last = -1;
    reset_dut(1, 2);
    n_cmp++;
    if (otk[1] !== 1'b1) begin
      n_bad++; $display("FAIL anim_first: got %b want 1", otk[1]);
    end
    for (int n = 1; n <= 24576; n++) begin
      step(1);
      if (otk[1]) begin
        ticks++;
        last = n;
      end
    end
    n_cmp++;
    if (ticks !== 1 || last !== 24576) begin
      n_bad++; $display("FAIL anim_ticks: got count=%0d last=%0d want 1 24576", ticks, last);
    end
    n_cmp++;
    if (ofc[1] !== 8'd8) begin
      n_bad++; $display("FAIL anim_frame_count: got %0d want 8", ofc[1]);
    end
    report_model(1, "model_anim");
  endtask

  task automatic test_wrap();
    int tick_diff = 0;
    reset_dut(2, 2);
    for (int n = 1; n <= 21421; n++) begin
      step(2);
      if (otk[2] !== ofs[2]) tick_diff++;
      if (n == 21420) begin
        n_cmp++;
        if ({ofs[2], ofc[2]} !== {1'b1, 8'd255}) begin
          n_bad++; $display("FAIL wrap_pre: got fs=%b fc=%0d want 1 255", ofs[2], ofc[2]);
        end
      end
      if (n == 21421) begin
        n_cmp++;
        if (ofc[2] !== 8'd0) begin
          n_bad++; $display("FAIL wrap_post: got fc=%0d want 0", ofc[2]);
        end
      end
    end
    n_cmp++;
    if (tick_diff !== 0) begin
      n_bad++; $display("FAIL wrap_tick_eq_fs: got %0d differing cycles want 0", tick_diff);
    end
    report_model(2, "model_wrap");
  endtask

  task automatic test_reset_mid();
    reset_dut(1, 2);
    for (int n = 1; n <= 2768; n++) step(1);
    n_cmp++;
    if ({ox[1], oy[1], ohs[1], ovs[1]} !== {10'd80, 10'd28, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL midrst_pre: got x=%0d y=%0d hs=%b vs=%b want 80 28 0 0", ox[1], oy[1], ohs[1], ovs[1]);
    end
    rst[1] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ox[1], oy[1], ohs[1], ovs[1], obd[1], ofc[1]} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL midrst_post: x=%0d y=%0d hs=%b vs=%b bd=%b fc=%0d want 0 0 1 1 0 0",
               ox[1], oy[1], ohs[1], ovs[1], obd[1], ofc[1]);
    end
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    model_reset(1);
    model_check(1);
    for (int n = 1; n <= 300; n++) step(1);
    report_model(1, "model_after_mid_reset");
  endtask

  task automatic test_pipe_sweep();
    logic e;
    reset_dut(2, 2);
    for (int n = 1; n <= 12; n++) begin
      step(2);
      if (n == 8 || n == 9) begin
        e = (n == 8);
        n_cmp++;
        if (ohs[2] !== e) begin
          n_bad++; $display("FAIL pd0_hs@%0d: got %b want %b", n, ohs[2], e);
        end
      end
      if (n == 7 || n == 8) begin
        e = (n == 7);
        n_cmp++;
        if (obd[2] !== e) begin
          n_bad++; $display("FAIL pd0_blank_d@%0d: got %b want %b", n, obd[2], e);
        end
      end
    end
    report_model(2, "model_pd0");
    reset_dut(1, 2);
    for (int n = 1; n <= 100; n++) begin
      step(1);
      if (n == 75 || n == 76 || n == 91 || n == 92) begin
        e = !(n == 76 || n == 91);
        n_cmp++;
        if (ohs[1] !== e) begin
          n_bad++; $display("FAIL pd4_hs@%0d: got %b want %b", n, ohs[1], e);
        end
      end
    end
    report_model(1, "model_pd4");
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      merr[d] = 0;
      model_reset(d);
    end
    repeat (3) @(negedge clk);
    rst = 3'b000;
    test_reset();
    test_line();
    test_frame();
    test_anim();
    test_wrap();
    test_reset_mid();
    test_pipe_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
